// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   dmem_state_e : run / pass / fail status of the responder
//   log_entry_t  : one write-log record {addr, data}
//   word_aligned : true when a byte address is 32-bit aligned
//   sat_inc16    : 16-bit increment that sticks at all-ones
package dmem_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/log_fifo.sv
// Write-log FIFO: registered-head, no fall-through queue of log entries.
// Ports:
//   clk, reset (async, active-low)
//   push, wdata : enqueue request and entry
//   ready       : consumer accepts the head this cycle
//   valid       : queue non-empty (registered)
//   head        : oldest entry, held stable until popped
//   ovf         : sticky, set when a push was dropped at full without a pop
module log_fifo
  import dmem_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = log_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t wdata,
  input  logic   ready,
  output logic   valid,
  output entry_t head,
  output logic   ovf
);

  localparam int PW = $clog2(DEPTH);

  entry_t      mem_r [DEPTH];
  logic [PW:0] wr_ptr_r;
  logic [PW:0] rd_ptr_r;
  logic [PW:0] wr_ptr_nxt_s;
  logic [PW:0] rd_ptr_nxt_s;
  logic        valid_r;
  logic        ovf_r;
  logic        full_s;
  logic        pop_s;
  logic        push_ok_s;
  logic        drop_s;

  // Pointer arithmetic; the extra MSB separates full from empty.
  always_comb begin
    full_s    = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    pop_s     = valid_r && ready;
    // At full a simultaneous pop frees the slot the push lands in.
    push_ok_s = push && (!full_s || pop_s);
    drop_s    = push && full_s && !pop_s;
    if (push_ok_s) begin
      wr_ptr_nxt_s = wr_ptr_r + {{PW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + {{PW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Pointers, registered non-empty flag and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      valid_r  <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // Entry storage; contents are not cleared, writes are held off in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // storage keeps its contents; pointers alone define occupancy
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r[PW-1:0]] <= wdata;
    end
  end

  assign head  = mem_r[rd_ptr_r[PW-1:0]];
  assign valid = valid_r;
  assign ovf   = ovf_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for processor test benches: a word RAM with a
// completion mailbox, a write log and a pass/fail status machine.
// Ports:
//   clk, reset (async, active-low)
//   memwrite, dataadr, writedata : processor store interface
//   readdata                     : combinational load data (0 when out of range)
//   log_valid/log_ready/log_addr/log_data : write-log stream, head held until taken
//   log_ovf                      : sticky, a logged store was lost at full
//   done / fail                  : registered pass / fail status
//   wr_count                     : stores accepted while running, saturating
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LOG_DEPTH   = 8,
  parameter logic [31:0] DONE_ADDR   = 32'd84,
  parameter logic [31:0] EXPECT      = 32'hFFFFFFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_ovf,
  output logic        done,
  output logic        fail,
  output logic [15:0] wr_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] ram_r [DEPTH_WORDS];
  dmem_state_e state_r;
  logic        done_r;
  logic        fail_r;
  logic [15:0] wr_count_r;

  logic [AW-1:0] idx_s;
  logic          in_range_s;
  logic          mailbox_s;
  logic          legal_s;
  logic          accept_s;
  logic          ram_we_s;
  log_entry_t    push_entry_s;
  log_entry_t    head_s;

  // Address decode and store classification.
  always_comb begin
    idx_s      = dataadr[AW+1:2];
    // Range test uses the whole word address so high bits cannot alias.
    in_range_s = ({2'b00, dataadr[31:2]} < 32'(DEPTH_WORDS));
    mailbox_s  = (dataadr == DONE_ADDR);
    legal_s    = (word_aligned(dataadr) && in_range_s) || mailbox_s;
    accept_s   = memwrite && (state_r == RUN);
    // The mailbox never aliases RAM even though it decodes in range.
    ram_we_s   = accept_s && legal_s && !mailbox_s;
    push_entry_s.addr = dataadr;
    push_entry_s.data = writedata;
  end

  // Combinational load path; out-of-range words read as zero.
  always_comb begin
    if (in_range_s) begin
      readdata = ram_r[idx_s];
    end else begin
      readdata = 32'h0000_0000;
    end
  end

  // RAM write port; contents survive reset and stores during reset are lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // RAM keeps its contents across reset
    end else if (ram_we_s) begin
      ram_r[idx_s] <= writedata;
    end
  end

  // Status machine with registered done/fail; PASS and FAIL hold until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RUN;
      done_r  <= 1'b0;
      fail_r  <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (accept_s && mailbox_s) begin
            if (writedata == EXPECT) begin
              state_r <= PASS;
              done_r  <= 1'b1;
              fail_r  <= 1'b0;
            end else begin
              state_r <= FAIL;
              done_r  <= 1'b0;
              fail_r  <= 1'b1;
            end
          end else if (accept_s && !legal_s) begin
            state_r <= FAIL;
            done_r  <= 1'b0;
            fail_r  <= 1'b1;
          end else begin
            state_r <= RUN;
            done_r  <= 1'b0;
            fail_r  <= 1'b0;
          end
        end
        PASS: begin
          state_r <= PASS;
          done_r  <= 1'b1;
          fail_r  <= 1'b0;
        end
        FAIL: begin
          state_r <= FAIL;
          done_r  <= 1'b0;
          fail_r  <= 1'b1;
        end
        default: begin
          // A corrupted state encoding is reported as a failure.
          state_r <= FAIL;
          done_r  <= 1'b0;
          fail_r  <= 1'b1;
        end
      endcase
    end
  end

  // Accepted-store counter, sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count_r <= 16'h0000;
    end else if (accept_s) begin
      wr_count_r <= sat_inc16(wr_count_r);
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  // Every store accepted while running is logged, legal or not.
  log_fifo #(
    .DEPTH   (LOG_DEPTH),
    .entry_t (log_entry_t)
  ) u_log_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept_s),
    .wdata (push_entry_s),
    .ready (log_ready),
    .valid (log_valid),
    .head  (head_s),
    .ovf   (log_ovf)
  );

  assign log_addr = head_s.addr;
  assign log_data = head_s.data;
  assign done     = done_r;
  assign fail     = fail_r;
  assign wr_count = wr_count_r;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic        log_ready = 1'b0;
  logic [31:0] readdata;
  logic        log_valid;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_ovf;
  logic        done;
  logic        fail;
  logic [15:0] wr_count;

  int compared = 0;
  int mismatched = 0;

  // Reference model: plain memory array, entry queue, status flags.
  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  logic [31:0] m_mem [64];
  bit          m_known [64];
  ent_t        m_q [$];
  bit          m_pass = 1'b0;
  bit          m_fail = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_count = 0;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .log_valid (log_valid),
    .log_ready (log_ready),
    .log_addr  (log_addr),
    .log_data  (log_data),
    .log_ovf   (log_ovf),
    .done      (done),
    .fail      (fail),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int w;
    cmp("done", 32'(done), 32'(m_pass));
    cmp("fail", 32'(fail), 32'(m_fail));
    cmp("log_ovf", 32'(log_ovf), 32'(m_ovf));
    cmp("wr_count", 32'(wr_count), 32'(m_count));
    cmp("log_valid", 32'(log_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      cmp("log_addr", log_addr, m_q[0].a);
      cmp("log_data", log_data, m_q[0].d);
    end
    w = int'(dataadr >> 2);
    if (w >= 64) begin
      cmp("readdata_oor", readdata, 32'h0);
    end else if (m_known[w]) begin
      cmp("readdata", readdata, m_mem[w]);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pass = 1'b0;
    m_fail = 1'b0;
    m_ovf = 1'b0;
    m_count = 0;
  endtask

  // Apply the rules for one rising edge using the inputs currently driven.
  task automatic model_step();
    bit acc, pop, full;
    int w;
    if (!reset) return;
    acc  = memwrite && !m_pass && !m_fail;
    pop  = (m_q.size() > 0) && log_ready;
    full = (m_q.size() == 8);
    w = int'(dataadr >> 2);
    if (acc) begin
      if (m_count < 65535) m_count++;
      if (dataadr == 32'd84) begin
        if (writedata == 32'hFFFF_FFFC) m_pass = 1'b1;
        else m_fail = 1'b1;
      end else if (dataadr[1:0] != 2'b00 || w >= 64) begin
        m_fail = 1'b1;
      end else begin
        m_mem[w] = writedata;
        m_known[w] = 1'b1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      if (full && !pop) m_ovf = 1'b1;
      else m_q.push_back('{dataadr, writedata});
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    memwrite = we;
    dataadr = a;
    writedata = d;
    log_ready = rdy;
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    memwrite = 1'b0;
    log_ready = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] saved;
    logic [31:0] d8;
    int w;
    int r;
    int rdy_pct;

    do_reset();

    // Fill RAM (the mailbox word cannot be written) with random data.
    for (int i = 0; i < 64; i++) begin
      if (i != 21) begin
        drive(1'b1, 32'(i * 4), $urandom, 1'b1);
        tick();
      end
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    tick();

    // Store 7 to 80 then load it back.
    do_reset();
    drive(1'b1, 32'd80, 32'd7, 1'b0);
    tick();
    drive(1'b0, 32'd80, 32'd0, 1'b0);
    cmp("s1_readdata", readdata, 32'd7);
    cmp("s1_wr_count", 32'(wr_count), 32'd1);
    cmp("s1_log_valid", 32'(log_valid), 32'd1);
    cmp("s1_log_addr", log_addr, 32'd80);
    cmp("s1_log_data", log_data, 32'd7);
    cmp("s1_running", 32'({done, fail}), 32'd0);
    tick();

    // Pass mailbox, then a dropped store.
    drive(1'b1, 32'd84, 32'hFFFF_FFFC, 1'b0);
    tick();
    saved = m_mem[0];
    drive(1'b1, 32'd0, 32'h5555_5555, 1'b0);
    cmp("s2_done", 32'(done), 32'd1);
    cmp("s2_fail", 32'(fail), 32'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    cmp("s2_dropped_count", 32'(wr_count), 32'd2);
    cmp("s2_dropped_ram", readdata, saved);
    tick();

    // Wrong mailbox value, then misaligned store.
    do_reset();
    drive(1'b1, 32'd84, 32'd5, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    cmp("s3_fail_mbox", 32'(fail), 32'd1);
    cmp("s3_done_mbox", 32'(done), 32'd0);
    tick();
    do_reset();
    saved = m_mem[32];
    drive(1'b1, 32'h82, 32'h0000_ABCD, 1'b0);
    tick();
    drive(1'b0, 32'h80, 32'd0, 1'b0);
    cmp("s3_fail_misalign", 32'(fail), 32'd1);
    cmp("s3_ram_unchanged", readdata, saved);
    tick();

    // Fill the log, push+pop at full, then overflow and drain in order.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 32'(100 + i), 1'b0);
      tick();
    end
    drive(1'b1, 32'd32, 32'd108, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    cmp("s4_no_ovf_pushpop", 32'(log_ovf), 32'd0);
    tick();
    drive(1'b1, 32'd36, 32'd109, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    cmp("s4_ovf", 32'(log_ovf), 32'd1);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      cmp("s4_drain_addr", log_addr, 32'((k + 1) * 4));
      cmp("s4_drain_data", log_data, 32'(101 + k));
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    cmp("s4_empty", 32'(log_valid), 32'd0);
    tick();

    // Asynchronous reset mid-run with a non-empty log.
    do_reset();
    d8 = $urandom;
    drive(1'b1, 32'd8, d8, 1'b0);
    tick();
    drive(1'b1, 32'd84, 32'hFFFF_FFFC, 1'b0);
    tick();
    saved = m_mem[3];
    drive(1'b0, 32'd8, 32'd0, 1'b0);
    cmp("s5_pre_done", 32'(done), 32'd1);
    cmp("s5_pre_valid", 32'(log_valid), 32'd1);
    reset = 1'b0;
    #1;
    cmp("s5_valid_drop", 32'(log_valid), 32'd0);
    cmp("s5_count_drop", 32'(wr_count), 32'd0);
    cmp("s5_done_drop", 32'(done), 32'd0);
    model_reset();
    tick();
    drive(1'b1, 32'd12, 32'hDEAD_BEEF, 1'b0);
    tick();
    @(negedge clk);
    memwrite = 1'b0;
    reset = 1'b1;
    drive(1'b0, 32'd8, 32'd0, 1'b0);
    cmp("s5_ram_survives", readdata, d8);
    tick();
    drive(1'b0, 32'd12, 32'd0, 1'b0);
    cmp("s5_store_in_reset_lost", readdata, saved);
    tick();

    // Randomized episodes against the model.
    for (int ep = 0; ep < 15; ep++) begin
      do_reset();
      rdy_pct = (ep * 7) % 100;
      for (int c = 0; c < 50; c++) begin
        r = $urandom_range(0, 99);
        w = $urandom_range(0, 63);
        if (w == 21) w = 20;
        if (r < 45) begin
          drive(1'b1, 32'(w * 4), $urandom, $urandom_range(0, 99) < rdy_pct);
        end else if (r < 75) begin
          drive(1'b0, $urandom_range(0, 300), $urandom, $urandom_range(0, 99) < rdy_pct);
        end else if (r < 80) begin
          drive(1'b1, 32'd84, 32'hFFFF_FFFC, $urandom_range(0, 99) < rdy_pct);
        end else if (r < 83) begin
          drive(1'b1, 32'd84, $urandom, $urandom_range(0, 99) < rdy_pct);
        end else if (r < 86) begin
          drive(1'b1, 32'(w * 4 + $urandom_range(1, 3)), $urandom, 1'b1);
        end else if (r < 89) begin
          drive(1'b1, 32'($urandom_range(64, 4000) * 4), $urandom, 1'b1);
        end else begin
          drive(1'b0, 32'(w * 4), 32'd0, $urandom_range(0, 99) < rdy_pct);
        end
        tick();
      end
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DEPTH_WORDS, 64, number of 32-bit RAM words.
- LOG_DEPTH, 8, write-log FIFO entries (power of two).
- DONE_ADDR, 32'd84, byte address of the completion mailbox.
- EXPECT, 32'hFFFFFFFC, mailbox value meaning pass.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, asynchronous, active-low reset (asserted at 0).
- memwrite, in, 1, processor store strobe.
- dataadr, in, 32, processor byte address.
- writedata, in, 32, processor store data.
- readdata, out, 32, load data, combinational from dataadr.
- log_valid, out, 1, write-log FIFO non-empty.
- log_ready, in, 1, host accepts the log head.
- log_addr, out, 32, head-entry address.
- log_data, out, 32, head-entry data.
- log_ovf, out, 1, sticky flag: a logged write was lost.
- done, out, 1, mailbox hit with EXPECT (pass).
- fail, out, 1, illegal store or wrong mailbox value.
- wr_count, out, 16, accepted-store counter, saturating.

Function
REQ-003 readdata SHALL equal RAM[dataadr[log2(DEPTH_WORDS)+1:2]] combinationally; out-of-range addresses SHALL read 0.
REQ-004 A store SHALL be legal iff memwrite=1, dataadr[1:0]=0 and the word index < DEPTH_WORDS, or dataadr==DONE_ADDR.
REQ-005 FSM states SHALL be RUN, PASS and FAIL; reset enters RUN; PASS and FAIL are terminal until reset.
REQ-006 In RUN, a legal non-mailbox store SHALL write RAM at the clock edge; a load in the same cycle SHALL return the old word.
REQ-007 In RUN, a store to DONE_ADDR with writedata==EXPECT SHALL move to PASS next cycle; any other data SHALL move to FAIL; the mailbox SHALL NOT alias RAM.
REQ-008 In RUN, an illegal store (misaligned, or out of range and not the mailbox) SHALL move to FAIL and SHALL NOT write RAM.
REQ-009 done SHALL be 1 exactly in PASS; fail SHALL be 1 exactly in FAIL; both SHALL be registered outputs.
REQ-010 In PASS or FAIL, stores SHALL be dropped: no RAM write, no log entry, no count.
REQ-011 Each store accepted in RUN (including mailbox and illegal stores) SHALL push {dataadr, writedata} into the log FIFO and increment wr_count, saturating at 16'hFFFF.
REQ-012 Log FIFO handshake: the head pops when log_valid && log_ready. log_addr and log_data SHALL be stable while log_valid=1 and log_ready=0.
REQ-013 Log FIFO full, with a push and no pop in the same cycle: the push SHALL be discarded and log_ovf set (sticky). A push and a pop together at full SHALL both succeed.
REQ-014 Log FIFO empty, with a push: log_valid SHALL rise on the next cycle; there is no fall-through.
REQ-015 Pointers SHALL wrap modulo LOG_DEPTH, with one extra bit for full/empty discrimination.

Reset
REQ-016 reset=0 SHALL asynchronously force the state to RUN, and done, fail, log_valid, log_ovf, wr_count and the FIFO pointers to 0.
REQ-017 RAM contents SHALL NOT be cleared by reset. A store coincident with reset assertion SHALL be lost.
REQ-018 Release of reset SHALL take effect at the first rising clk edge after reset=1.

Structure
REQ-019 A shared package dmem_pkg SHALL hold the state enum (RUN, PASS, FAIL) and the log-entry struct {addr, data}.
REQ-020 The log FIFO SHALL be a sub-module log_fifo, parameterised by depth and entry type.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Store 7 to 80, then load 80: readdata=7, wr_count=1, log entry {80,7}, state RUN.
- Store 0xFFFFFFFC to 84: done=1 on the next cycle, fail=0; a later store to 0 is dropped (wr_count unchanged).
- Store 5 to 84: fail=1 on the next cycle; store to 0x82 (misaligned) from a fresh reset: fail=1 and RAM unchanged.
- log_ready=0, 9 stores with LOG_DEPTH=8: log_ovf=1, 8 entries drained in order. At full, push+pop in the same cycle: no overflow.
- Reset asserted mid-run with log_valid=1: log_valid, wr_count and done drop immediately without a clk edge; RAM data survives.
